// File: rtl/apb_master_sequencer.sv
// Single-beat request to APB SETUP/ACCESS sequencer.
// Flags out-of-range slaves and PREADY timeouts so the upstream bridge always gets a response.
module apb_master_sequencer #(
    parameter int unsigned NUM_SLAVES = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic        psel_en,
    output logic        PENABLE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_DERR   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             rsp_err_d;
    logic [DW-1:0]    rsp_rdata_d;
    logic             accept;
    logic             decode_err;

    assign accept     = req_valid && req_ready;
    assign decode_err = 32'(req_addr[23:16]) >= NUM_SLAVES;

    // State and timeout counter
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next state plus the response payload computed on the way into RESP
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_d = decode_err ? S_DERR : S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                cnt_d = cnt + CNT_W'(1);
                // PREADY wins over the timeout on the final allowed cycle
                if (PREADY) begin
                    state_d   = S_RESP;
                    rsp_err_d = PSLVERR;
                    if (!PWRITE && !PSLVERR) begin
                        rsp_rdata_d = PRDATA;
                    end
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = S_RESP;
                    rsp_err_d = 1'b1;
                end
            end
            S_DERR: begin
                state_d   = S_RESP;
                rsp_err_d = 1'b1;
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs, decoded from the next state
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            req_ready <= 1'b0;
            psel_en   <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
        end else begin
            req_ready <= (state_d == S_IDLE);
            psel_en   <= (state_d == S_SETUP) || (state_d == S_ACCESS);
            PENABLE   <= (state_d == S_ACCESS);
            rsp_valid <= (state_d == S_RESP);
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            if (accept) begin
                PADDR  <= req_addr;
                PWRITE <= req_write;
                PWDATA <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_sequencer.sv
// Directed bench for apb_master_sequencer: latency, wait states, decode error, timeout,
// slave error, back-to-back spacing and reset mid-transfer.
module tb_apb_master_sequencer;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        psel_en;
    logic        PENABLE;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    apb_master_sequencer #(.NUM_SLAVES(2), .TIMEOUT(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .psel_en(psel_en), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("wait_ready", 32'(req_ready), 32'd1);
    endtask

    // One transfer with wait_cycles ACCESS cycles of PREADY low before PREADY high
    task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int wait_cycles, input logic slverr,
                            input logic exp_err, input logic [31:0] exp_rdata);
        wait_ready();
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        PRDATA    = rdata;
        PSLVERR   = slverr;
        PREADY    = 1'b0;
        check("idle_psel", 32'(psel_en), 32'd0);
        step();
        req_valid = 1'b0;
        check("setup_psel", 32'(psel_en), 32'd1);
        check("setup_penable", 32'(PENABLE), 32'd0);
        check("setup_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i <= wait_cycles; i++) begin
            step();
            check("access_psel", 32'(psel_en), 32'd1);
            check("access_penable", 32'(PENABLE), 32'd1);
            check("access_paddr", PADDR, addr);
            check("access_pwrite", 32'(PWRITE), 32'(wr));
            if (wr) check("access_pwdata", PWDATA, wdata);
            check("access_rsp_valid", 32'(rsp_valid), 32'd0);
            PREADY = (i == wait_cycles);
        end
        step();
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        check("resp_valid", 32'(rsp_valid), 32'd1);
        check("resp_err", 32'(rsp_err), 32'(exp_err));
        check("resp_rdata", rsp_rdata, exp_rdata);
        check("resp_psel", 32'(psel_en), 32'd0);
        check("resp_penable", 32'(PENABLE), 32'd0);
        step();
        check("post_valid", 32'(rsp_valid), 32'd0);
        check("post_ready", 32'(req_ready), 32'd1);
    endtask

    // Out-of-range slave: no APB activity, error response two cycles after accept
    task automatic run_derr(input logic [31:0] addr);
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        PRDATA    = 32'hCAFE_F00D;
        PREADY    = 1'b1;
        step();
        req_valid = 1'b0;
        check("derr_psel1", 32'(psel_en), 32'd0);
        check("derr_valid1", 32'(rsp_valid), 32'd0);
        step();
        check("derr_valid2", 32'(rsp_valid), 32'd1);
        check("derr_err", 32'(rsp_err), 32'd1);
        check("derr_rdata", rsp_rdata, 32'd0);
        check("derr_psel2", 32'(psel_en), 32'd0);
        check("derr_penable", 32'(PENABLE), 32'd0);
        step();
        PREADY = 1'b0;
        check("derr_post_valid", 32'(rsp_valid), 32'd0);
        check("derr_post_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        // Reset values
        #1 HRESETn = 1'b0;
        #2;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_psel", 32'(psel_en), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_paddr", PADDR, 32'd0);
        repeat (2) step();
        HRESETn = 1'b1;
        step();
        check("idle_ready", 32'(req_ready), 32'd1);

        // 1: read slave 1, PREADY in first ACCESS
        run_xfer(1'b0, 32'h0001_0010, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 32'hDEAD_BEEF);

        // 2: write with 3 wait states; PREADY arrives on the last allowed ACCESS cycle
        run_xfer(1'b1, 32'h0000_0004, 32'h1234_5678, 32'hDEAD_BEEF, 3, 1'b0, 1'b0, 32'h0);

        // 3: decode errors, well past and exactly at NUM_SLAVES
        run_derr(32'h0005_0000);
        run_derr(32'h0002_0000);

        // 4: PREADY stuck low, TIMEOUT=4
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0100;
        PRDATA    = 32'h5555_AAAA;
        PREADY    = 1'b0;
        step();
        req_valid = 1'b0;
        check("to_setup_psel", 32'(psel_en), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("to_access_penable", 32'(PENABLE), 32'd1);
            check("to_access_valid", 32'(rsp_valid), 32'd0);
        end
        step();
        check("to_psel", 32'(psel_en), 32'd0);
        check("to_penable", 32'(PENABLE), 32'd0);
        check("to_valid", 32'(rsp_valid), 32'd1);
        check("to_err", 32'(rsp_err), 32'd1);
        check("to_rdata", rsp_rdata, 32'd0);
        step();
        run_xfer(1'b0, 32'h0000_0200, 32'h0, 32'h0BAD_F00D, 1, 1'b0, 1'b0, 32'h0BAD_F00D);

        // 5: slave error on a read
        run_xfer(1'b0, 32'h0001_0000, 32'h0, 32'h1111_2222, 0, 1'b1, 1'b1, 32'h0);

        // 5b: req_valid held high, ready pulses every 4 cycles
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0001_0008;
        req_wdata = 32'hA5A5_A5A5;
        PREADY    = 1'b1;
        for (int k = 0; k < 12; k++) begin
            check("b2b_ready", 32'(req_ready), 32'((k % 4) == 0));
            check("b2b_valid", 32'(rsp_valid), 32'((k % 4) == 3));
            if (k == 11) req_valid = 1'b0;
            step();
        end
        PREADY = 1'b0;
        check("b2b_idle", 32'(req_ready), 32'd1);

        // 6: reset during ACCESS
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0300;
        step();
        req_valid = 1'b0;
        step();
        check("rst6_access", 32'(PENABLE), 32'd1);
        #2 HRESETn = 1'b0;
        #1;
        check("rst6_psel", 32'(psel_en), 32'd0);
        check("rst6_penable", 32'(PENABLE), 32'd0);
        check("rst6_ready", 32'(req_ready), 32'd0);
        check("rst6_valid", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst6_hold_valid", 32'(rsp_valid), 32'd0);
        end
        HRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst6_after_valid", 32'(rsp_valid), 32'd0);
        end
        run_xfer(1'b0, 32'h0001_0040, 32'h0, 32'h7777_8888, 0, 1'b0, 1'b0, 32'h7777_8888);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
